// File: rtl/rob_multiport.sv
`default_nettype none
// ============================================================================
// Module   : rob_multiport
// Purpose  : N-wide circular reorder buffer with in-order retire and flush.
// Revision : 1.0
// ============================================================================
module rob_multiport #(
  parameter int DEPTH  = 32,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ISSUE  = 2,
  parameter int WB     = 2,
  parameter int RD     = 4,
  parameter int COMMIT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [ISSUE-1:0]         disp_valid,
  input  logic [ISSUE-1:0]         disp_we,
  input  logic [ISSUE*REG_W-1:0]   disp_dest,
  output logic [ISSUE*TAG_W-1:0]   disp_tag,
  output logic                     full,
  input  logic [WB-1:0]            wb_valid,
  input  logic [WB*TAG_W-1:0]      wb_tag,
  input  logic [WB*DATA_W-1:0]     wb_data,
  input  logic [RD*TAG_W-1:0]      rd_tag,
  output logic [RD-1:0]            rd_ready,
  output logic [RD*DATA_W-1:0]     rd_data,
  output logic [COMMIT-1:0]        commit_valid,
  output logic [COMMIT-1:0]        commit_we,
  output logic [COMMIT*REG_W-1:0]  commit_addr,
  output logic [COMMIT*DATA_W-1:0] commit_data,
  output logic [COMMIT*TAG_W-1:0]  commit_tag,
  output logic [TAG_W:0]           count
);

  localparam int CNT_W = TAG_W + 1;

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [DEPTH-1:0]  r_we;
  logic [REG_W-1:0]  r_dest [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [TAG_W-1:0]  w_disp_idx [ISSUE];
  logic [CNT_W-1:0]  w_n_disp;
  logic [CNT_W-1:0]  w_n_acc;
  logic              w_accept;
  logic [TAG_W-1:0]  w_cidx [COMMIT];
  logic [COMMIT-1:0] w_cvalid;
  logic [CNT_W-1:0]  w_n_commit;
  logic              w_run;

  assign count    = r_count;
  assign full     = (CNT_W'(DEPTH) - r_count) < CNT_W'(ISSUE);
  assign w_accept = ~full;
  assign w_n_acc  = w_accept ? w_n_disp : '0;

  // Valid lanes are packed onto consecutive tags starting at tail.
  always_comb begin
    w_n_disp = '0;
    disp_tag = '0;
    for (int i = 0; i < ISSUE; i++) begin
      w_disp_idx[i] = r_tail + w_n_disp[TAG_W-1:0];
      disp_tag[i*TAG_W +: TAG_W] = w_disp_idx[i];
      if (disp_valid[i]) w_n_disp = w_n_disp + CNT_W'(1);
    end
  end

  // A lane retires only while every older lane also retires.
  always_comb begin
    w_n_commit   = '0;
    w_run        = ~(flush | rst);
    w_cvalid     = '0;
    commit_we    = '0;
    commit_addr  = '0;
    commit_data  = '0;
    commit_tag   = '0;
    for (int j = 0; j < COMMIT; j++) begin
      w_cidx[j] = r_head + TAG_W'(j);
      w_run     = w_run & r_valid[w_cidx[j]] & r_done[w_cidx[j]];
      w_cvalid[j] = w_run;
      if (w_run) begin
        w_n_commit = w_n_commit + CNT_W'(1);
        commit_we[j] = r_we[w_cidx[j]];
        commit_addr[j*REG_W +: REG_W]   = r_dest[w_cidx[j]];
        commit_data[j*DATA_W +: DATA_W] = r_data[w_cidx[j]];
        commit_tag[j*TAG_W +: TAG_W]    = w_cidx[j];
      end
    end
  end

  assign commit_valid = w_cvalid;

  // Later writeback ports override earlier ones, matching the write priority.
  always_comb begin
    rd_ready = '0;
    rd_data  = '0;
    for (int r = 0; r < RD; r++) begin
      if (r_done[rd_tag[r*TAG_W +: TAG_W]]) begin
        rd_ready[r] = 1'b1;
        rd_data[r*DATA_W +: DATA_W] = r_data[rd_tag[r*TAG_W +: TAG_W]];
      end
      for (int p = 0; p < WB; p++) begin
        if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == rd_tag[r*TAG_W +: TAG_W])) begin
          rd_ready[r] = 1'b1;
          rd_data[r*DATA_W +: DATA_W] = wb_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
      r_we    <= '0;
    end else begin
      for (int p = 0; p < WB; p++) begin
        if (wb_valid[p] && r_valid[wb_tag[p*TAG_W +: TAG_W]]) begin
          r_done[wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
          r_data[wb_tag[p*TAG_W +: TAG_W]] <= wb_data[p*DATA_W +: DATA_W];
        end
      end
      for (int j = 0; j < COMMIT; j++) begin
        if (w_cvalid[j]) begin
          r_valid[w_cidx[j]] <= 1'b0;
          r_done[w_cidx[j]]  <= 1'b0;
        end
      end
      // Dispatch targets only slots already free in registered state.
      if (w_accept) begin
        for (int i = 0; i < ISSUE; i++) begin
          if (disp_valid[i]) begin
            r_valid[w_disp_idx[i]] <= 1'b1;
            r_done[w_disp_idx[i]]  <= 1'b0;
            r_we[w_disp_idx[i]]    <= disp_we[i];
            r_dest[w_disp_idx[i]]  <= disp_dest[i*REG_W +: REG_W];
          end
        end
      end
      r_head  <= r_head + w_n_commit[TAG_W-1:0];
      r_tail  <= r_tail + w_n_acc[TAG_W-1:0];
      r_count <= r_count + w_n_acc - w_n_commit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_multiport
// Purpose  : Directed table-driven and sequence checks for rob_multiport.
// Revision : 1.0
// ============================================================================
module tb_rob_multiport;

  localparam int DEPTH = 32, TAG_W = 5, DATA_W = 32, REG_W = 5;
  localparam int ISSUE = 2, WB = 2, RD = 4, COMMIT = 2;

  logic                     clk = 1'b0;
  logic                     rst, flush;
  logic [ISSUE-1:0]         disp_valid, disp_we;
  logic [ISSUE*REG_W-1:0]   disp_dest;
  logic [ISSUE*TAG_W-1:0]   disp_tag;
  logic                     full;
  logic [WB-1:0]            wb_valid;
  logic [WB*TAG_W-1:0]      wb_tag;
  logic [WB*DATA_W-1:0]     wb_data;
  logic [RD*TAG_W-1:0]      rd_tag;
  logic [RD-1:0]            rd_ready;
  logic [RD*DATA_W-1:0]     rd_data;
  logic [COMMIT-1:0]        commit_valid, commit_we;
  logic [COMMIT*REG_W-1:0]  commit_addr;
  logic [COMMIT*DATA_W-1:0] commit_data;
  logic [COMMIT*TAG_W-1:0]  commit_tag;
  logic [TAG_W:0]           count;

  rob_multiport #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W),
    .ISSUE(ISSUE), .WB(WB), .RD(RD), .COMMIT(COMMIT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_we(disp_we), .disp_dest(disp_dest),
    .disp_tag(disp_tag), .full(full),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_data(rd_data),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_addr(commit_addr),
    .commit_data(commit_data), .commit_tag(commit_tag), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        chk;
    logic [1:0]  dv;
    logic [1:0]  dwe;
    logic [9:0]  dest;
    logic [1:0]  wv;
    logic [9:0]  wt;
    logic [63:0] wd;
    logic [9:0]  etag;
    logic [1:0]  ecv;
    logic [1:0]  ecwe;
    logic [9:0]  eca;
    logic [63:0] ecd;
    logic [9:0]  ect;
    logic [5:0]  ecount;
    logic        efull;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_idle();
    rst = 1'b0; flush = 1'b0;
    disp_valid = '0; disp_we = '0; disp_dest = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; rd_tag = '0;
  endtask

  // Advance one cycle, then leave inputs idle for the caller to override.
  task automatic cyc();
    @(posedge clk); #1;
    set_idle();
  endtask

  initial begin
    // Field order: rst chk dv dwe dest wv wt wd | etag ecv ecwe eca ecd ect ecount efull
    tbl[0]  = '{1'b0, 1'b1, 2'b11, 2'b11, {5'd4, 5'd3}, 2'b00, 10'd0, 64'd0,
                {5'd1, 5'd0}, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0, 6'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'b00, 2'b00, 10'd0, 2'b01, {5'd0, 5'd1}, {32'h0, 32'hBB},
                10'd0, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0, 6'd2, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 2'b00, 2'b00, 10'd0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'hAA},
                10'd0, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0, 6'd2, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2'b00, 2'b00, 10'd0, 2'b00, 10'd0, 64'd0,
                10'd0, 2'b11, 2'b11, {5'd4, 5'd3}, {32'hBB, 32'hAA}, {5'd1, 5'd0}, 6'd2, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 2'b00, 2'b00, 10'd0, 2'b00, 10'd0, 64'd0,
                10'd0, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0, 6'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'b00, 2'b00, 10'd0, 2'b00, 10'd0, 64'd0,
                10'd0, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0, 6'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 2'b11, 2'b11, {5'd2, 5'd1}, 2'b00, 10'd0, 64'd0,
                {5'd1, 5'd0}, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0, 6'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2'b11, 2'b01, {5'd6, 5'd5}, 2'b00, 10'd0, 64'd0,
                {5'd3, 5'd2}, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0, 6'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2'b00, 2'b00, 10'd0, 2'b11, {5'd3, 5'd2}, {32'h33, 32'h22},
                10'd0, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0, 6'd4, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 2'b00, 2'b00, 10'd0, 2'b00, 10'd0, 64'd0,
                10'd0, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0, 6'd4, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 2'b00, 2'b00, 10'd0, 2'b11, {5'd1, 5'd0}, {32'h11, 32'h10},
                10'd0, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0, 6'd4, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 2'b00, 2'b00, 10'd0, 2'b00, 10'd0, 64'd0,
                10'd0, 2'b11, 2'b11, {5'd2, 5'd1}, {32'h11, 32'h10}, {5'd1, 5'd0}, 6'd4, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 2'b00, 2'b00, 10'd0, 2'b00, 10'd0, 64'd0,
                10'd0, 2'b11, 2'b01, {5'd6, 5'd5}, {32'h33, 32'h22}, {5'd3, 5'd2}, 6'd2, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 2'b00, 2'b00, 10'd0, 2'b00, 10'd0, 64'd0,
                10'd0, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0, 6'd0, 1'b0};

    set_idle();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    set_idle();
    #1;
    check("reset.count", count, 0);
    check("reset.full", full, 0);
    check("reset.commit_valid", commit_valid, 0);
    check("reset.commit_we", commit_we, 0);
    check("reset.commit_addr", commit_addr, 0);
    check("reset.commit_data", commit_data, 0);
    check("reset.commit_tag", commit_tag, 0);
    check("reset.rd_ready", rd_ready, 0);
    check("reset.rd_data", rd_data, 0);
    check("reset.disp_tag", disp_tag, 0);

    // Basic pair retire and out-of-order completion
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      set_idle();
      rst = tbl[i].rst; disp_valid = tbl[i].dv; disp_we = tbl[i].dwe; disp_dest = tbl[i].dest;
      wb_valid = tbl[i].wv; wb_tag = tbl[i].wt; wb_data = tbl[i].wd;
      #1;
      if (tbl[i].chk) begin
        if (tbl[i].dv != 2'b00) check($sformatf("v%0d.disp_tag", i), disp_tag, tbl[i].etag);
        check($sformatf("v%0d.commit_valid", i), commit_valid, tbl[i].ecv);
        check($sformatf("v%0d.commit_we", i), commit_we, tbl[i].ecwe);
        check($sformatf("v%0d.commit_addr", i), commit_addr, tbl[i].eca);
        check($sformatf("v%0d.commit_data", i), commit_data, tbl[i].ecd);
        check($sformatf("v%0d.commit_tag", i), commit_tag, tbl[i].ect);
        check($sformatf("v%0d.count", i), count, tbl[i].ecount);
        check($sformatf("v%0d.full", i), full, tbl[i].efull);
      end
    end

    // Fill to 31 entries, blocked dispatch, then one retire releases full
    cyc(); rst = 1'b1;
    for (int k = 0; k < 15; k++) begin cyc(); disp_valid = 2'b11; disp_we = 2'b11; end
    cyc(); disp_valid = 2'b01;
    cyc(); #1;
    check("fill.count", count, 31);
    check("fill.full", full, 1);
    check("fill.tail", disp_tag[4:0], 31);
    cyc(); disp_valid = 2'b11;
    cyc(); #1;
    check("fill.blocked_count", count, 31);
    check("fill.blocked_tail", disp_tag[4:0], 31);
    wb_valid = 2'b01; wb_tag = {5'd0, 5'd0}; wb_data = {32'h0, 32'h5};
    cyc(); #1;
    check("fill.commit_one", commit_valid, 2'b01);
    check("fill.still_full", full, 1);
    cyc(); #1;
    check("fill.released", full, 0);
    check("fill.count30", count, 30);

    // Drain to head=tail=30, then dispatch across the wrap point
    cyc(); rst = 1'b1;
    for (int k = 0; k < 15; k++) begin cyc(); disp_valid = 2'b11; disp_we = 2'b11; end
    for (int k = 0; k < 15; k++) begin
      cyc(); wb_valid = 2'b11; wb_tag = {TAG_W'(2*k+1), TAG_W'(2*k)};
    end
    begin
      int n;
      n = 0;
      cyc(); #1;
      while (count != 0 && n < 40) begin cyc(); #1; n++; end
      check("wrap.drain", count, 0);
    end
    cyc(); disp_valid = 2'b11; disp_we = 2'b11; #1;
    check("wrap.tags_a", disp_tag, {5'd31, 5'd30});
    cyc(); disp_valid = 2'b11; disp_we = 2'b11; #1;
    check("wrap.tags_b", disp_tag, {5'd1, 5'd0});
    check("wrap.count2", count, 2);
    cyc(); wb_valid = 2'b11; wb_tag = {5'd31, 5'd30}; wb_data = {32'h31, 32'h30}; #1;
    check("wrap.count4", count, 4);
    check("wrap.no_early_commit", commit_valid, 2'b00);
    cyc(); wb_valid = 2'b11; wb_tag = {5'd1, 5'd0}; wb_data = {32'h101, 32'h100}; #1;
    check("wrap.cv_a", commit_valid, 2'b11);
    check("wrap.ct_a", commit_tag, {5'd31, 5'd30});
    check("wrap.cd_a", commit_data, {32'h31, 32'h30});
    cyc(); #1;
    check("wrap.cv_b", commit_valid, 2'b11);
    check("wrap.ct_b", commit_tag, {5'd1, 5'd0});
    check("wrap.cd_b", commit_data, {32'h101, 32'h100});
    check("wrap.count_b", count, 2);
    cyc(); #1;
    check("wrap.empty", count, 0);

    // Read bypass, port priority, and a non-writing entry retiring (tags 2..5)
    cyc(); disp_valid = 2'b11; disp_we = 2'b11;
    cyc(); disp_valid = 2'b11; disp_we = 2'b10;
    cyc();
    wb_valid = 2'b10; wb_tag = {5'd5, 5'd0}; wb_data = {32'h1234, 32'h0};
    rd_tag = {5'd4, 5'd4, 5'd4, 5'd5}; #1;
    check("byp.ready", rd_ready, 4'b0001);
    check("byp.data", rd_data, {96'h0, 32'h1234});
    cyc();
    wb_valid = 2'b11; wb_tag = {5'd4, 5'd4}; wb_data = {32'h5555, 32'hAAAA};
    rd_tag = {5'd5, 5'd4, 5'd3, 5'd2}; #1;
    check("byp.prio_ready", rd_ready, 4'b1100);
    check("byp.prio_data", rd_data, {32'h1234, 32'h5555, 64'h0});
    cyc();
    wb_valid = 2'b11; wb_tag = {5'd3, 5'd2}; wb_data = {32'h3, 32'h2};
    rd_tag = {15'd0, 5'd4}; #1;
    check("byp.stored_winner", rd_data[31:0], 32'h5555);
    cyc(); #1;
    check("we0.cv_a", commit_valid, 2'b11);
    check("we0.ct_a", commit_tag, {5'd3, 5'd2});
    cyc(); #1;
    check("we0.cv_b", commit_valid, 2'b11);
    check("we0.cwe_b", commit_we, 2'b10);
    check("we0.cd_b", commit_data, {32'h1234, 32'h5555});

    // Flush with 6 entries, a pending wb and retire-ready head
    cyc(); rst = 1'b1;
    for (int k = 0; k < 3; k++) begin cyc(); disp_valid = 2'b11; disp_we = 2'b11; end
    cyc(); wb_valid = 2'b11; wb_tag = {5'd1, 5'd0}; wb_data = {32'h71, 32'h70};
    cyc(); flush = 1'b1; wb_valid = 2'b01; wb_tag = {5'd0, 5'd2}; wb_data = {32'h0, 32'h77}; #1;
    check("flush.no_commit", commit_valid, 2'b00);
    check("flush.count_before", count, 6);
    cyc(); rd_tag = '0; #1;
    check("flush.count", count, 0);
    check("flush.tail", disp_tag, 10'd0);
    check("flush.stale_read", rd_ready, 4'b0000);
    check("flush.commit_valid", commit_valid, 2'b00);
    cyc(); wb_valid = 2'b01; wb_tag = {5'd0, 5'd2}; wb_data = {32'h0, 32'h99};
    cyc(); rd_tag = {15'd0, 5'd2}; #1;
    check("flush.old_wb_ignored", rd_ready, 4'b0000);
    check("flush.count_after_wb", count, 0);
    cyc(); disp_valid = 2'b11; #1;
    check("flush.realloc", disp_tag, {5'd1, 5'd0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
